avalon_blink_pio: RTL and testbench

- Avalon-MM slave output PIO. Parametrised successor to the single-register output PIO.
- Adds atomic set/clear registers, a per-bit blink mask and a programmable half-period counter.
- Supports free-running blink or a single delayed pulse, with a completion flag and interrupt.
- Sits on the HPS lightweight bridge and drives LEDs or pulse-delay outputs directly.

---
 rtl/avalon_blink_pio.sv | 160 ++++++++++++++++
 tb/tb_avalon_blink_pio.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/avalon_blink_pio.sv
// Avalon-MM output PIO with atomic set/clear, a per-bit blink mask and a
// programmable half-period counter for free-running blink or a one-shot pulse.
module avalon_blink_pio #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    CNT_WIDTH    = 24,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA   = '0,
    parameter logic [CNT_WIDTH-1:0]  RESET_PERIOD = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);
    localparam int CTRL_BITS = (DATA_WIDTH < 3) ? DATA_WIDTH : 3;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_CONTROL  = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;
    localparam logic [2:0] ADDR_OUTSET   = 3'd5;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd6;
    localparam logic [2:0] ADDR_COUNT    = 3'd7;

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic [CNT_WIDTH-1:0]  period_q, period_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  run_q, run_d;
    logic                  oneshot_q, oneshot_d;
    logic                  irq_en_q, irq_en_d;
    logic                  done_q, done_d;
    logic                  phase_q, phase_d;

    logic                  wr_en;
    logic                  ctrl_wr;
    logic [2:0]            ctrl_wd;
    logic                  period_nz;
    logic [CNT_WIDTH-1:0]  reload_val;
    logic                  done_set;
    logic [31:0]           rd_wide;

    always_comb begin
        wr_en      = chipselect & ~write_n;
        ctrl_wr    = wr_en && (address == ADDR_CONTROL);
        ctrl_wd    = '0;
        ctrl_wd[CTRL_BITS-1:0] = writedata[CTRL_BITS-1:0];
        period_nz  = (period_q != '0);
        reload_val = period_nz ? (period_q - CNT_WIDTH'(1)) : '0;

        data_d    = data_q;
        mask_d    = mask_q;
        period_d  = period_q;
        run_d     = run_q;
        oneshot_d = oneshot_q;
        irq_en_d  = irq_en_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        done_set  = 1'b0;

        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d   = writedata;
                ADDR_MASK:     mask_d   = writedata;
                ADDR_PERIOD:   period_d = writedata[CNT_WIDTH-1:0];
                ADDR_CONTROL: begin
                    run_d     = ctrl_wd[0];
                    oneshot_d = ctrl_wd[1];
                    irq_en_d  = ctrl_wd[2];
                end
                ADDR_OUTSET:   data_d   = data_q | writedata;
                ADDR_OUTCLEAR: data_d   = data_q & ~writedata;
                default: ;
            endcase
        end

        // Only a 0->1 RUN transition restarts; a repeated RUN=1 keeps counting.
        if (ctrl_wr && ctrl_wd[0] && !run_q) begin
            cnt_d   = reload_val;
            phase_d = 1'b0;
        end else if (ctrl_wr && !ctrl_wd[0]) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (run_q) begin
            if (!period_nz) begin
                cnt_d = '0;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
            end else begin
                cnt_d   = reload_val;
                phase_d = ~phase_q;
                // End of the high half of a one-shot: pulse finished.
                if (oneshot_q && phase_q) begin
                    run_d    = 1'b0;
                    done_set = 1'b1;
                end
            end
        end

        done_d = done_q;
        if (wr_en && (address == ADDR_STATUS) && ctrl_wd[1]) begin
            done_d = 1'b0;
        end
        if (done_set) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q    <= RESET_DATA;
            mask_q    <= '0;
            period_q  <= RESET_PERIOD;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            oneshot_q <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            phase_q   <= 1'b0;
        end else begin
            data_q    <= data_d;
            mask_q    <= mask_d;
            period_q  <= period_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            oneshot_q <= oneshot_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
            phase_q   <= phase_d;
        end
    end

    always_comb begin
        rd_wide = '0;
        case (address)
            ADDR_DATA:    rd_wide[DATA_WIDTH-1:0] = data_q;
            ADDR_MASK:    rd_wide[DATA_WIDTH-1:0] = mask_q;
            ADDR_PERIOD:  rd_wide[CNT_WIDTH-1:0]  = period_q;
            ADDR_CONTROL: rd_wide[2:0]            = {irq_en_q, oneshot_q, run_q};
            ADDR_STATUS:  rd_wide[1:0]            = {done_q, run_q & period_nz};
            ADDR_COUNT:   rd_wide[CNT_WIDTH-1:0]  = cnt_q;
            default:      rd_wide                 = '0;
        endcase
    end

    assign readdata = rd_wide[DATA_WIDTH-1:0];
    assign irq      = done_q & irq_en_q;

    generate
        for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_out
            assign out_port[gi] = data_q[gi] ^ (mask_q[gi] & phase_q);
        end
    endgenerate

endmodule

// File: tb/tb_avalon_blink_pio.sv
// Directed bench for avalon_blink_pio: register table plus blink, one-shot,
// period-change and asynchronous-reset sequences.
module tb_avalon_blink_pio;
    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] out_port;
    logic        irq;

    int checks = 0;
    int errors = 0;

    avalon_blink_pio #(
        .DATA_WIDTH  (32),
        .CNT_WIDTH   (24),
        .RESET_DATA  (32'h5),
        .RESET_PERIOD(24'h0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic [31:0] exp_out;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic wr, logic [2:0] a, logic [31:0] d,
                                logic [31:0] er, logic [31:0] eo, logic ei);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.exp_rd = er; v.exp_out = eo; v.exp_irq = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0; write_n = 1'b1;
        $display("wr addr=%0d data=%h out_port=%h irq=%b", a, d, out_port, irq);
    endtask

    task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        check(name, readdata, exp);
        chipselect = 1'b0;
        $display("rd addr=%0d data=%h", a, readdata);
    endtask

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        #12;
        check("rst_out", out_port, 32'h5);
        check("rst_irq", {31'd0, irq}, 32'h0);
        #10;
        reset_n = 1'b1;
        step(1);

        vecs[0]  = mk(1'b0, 3'd0, 32'h0,  32'h5,  32'h5,  1'b0);
        vecs[1]  = mk(1'b0, 3'd1, 32'h0,  32'h0,  32'h5,  1'b0);
        vecs[2]  = mk(1'b0, 3'd2, 32'h0,  32'h0,  32'h5,  1'b0);
        vecs[3]  = mk(1'b0, 3'd3, 32'h0,  32'h0,  32'h5,  1'b0);
        vecs[4]  = mk(1'b0, 3'd4, 32'h0,  32'h0,  32'h5,  1'b0);
        vecs[5]  = mk(1'b0, 3'd5, 32'h0,  32'h0,  32'h5,  1'b0);
        vecs[6]  = mk(1'b0, 3'd6, 32'h0,  32'h0,  32'h5,  1'b0);
        vecs[7]  = mk(1'b0, 3'd7, 32'h0,  32'h0,  32'h5,  1'b0);
        vecs[8]  = mk(1'b1, 3'd0, 32'hF0, 32'h0,  32'hF0, 1'b0);
        vecs[9]  = mk(1'b1, 3'd5, 32'h0F, 32'h0,  32'hFF, 1'b0);
        vecs[10] = mk(1'b1, 3'd6, 32'h30, 32'h0,  32'hCF, 1'b0);
        vecs[11] = mk(1'b0, 3'd0, 32'h0,  32'hCF, 32'hCF, 1'b0);
        vecs[12] = mk(1'b0, 3'd5, 32'h0,  32'h0,  32'hCF, 1'b0);
        vecs[13] = mk(1'b0, 3'd6, 32'h0,  32'h0,  32'hCF, 1'b0);
        vecs[14] = mk(1'b1, 3'd1, 32'h1,  32'h0,  32'hCF, 1'b0);
        vecs[15] = mk(1'b0, 3'd1, 32'h0,  32'h1,  32'hCF, 1'b0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                rd_check($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
                step(1);
            end
            check($sformatf("vec%0d_out", i), out_port, vecs[i].exp_out);
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end

        // Free-running blink, PERIOD=4, with a CONTROL=1 rewrite mid-run.
        bus_write(3'd2, 32'd4);
        bus_write(3'd3, 32'h1);
        for (int k = 0; k < 14; k++) begin
            address = 3'd7; chipselect = 1'b1; write_n = 1'b1;
            #1;
            check($sformatf("blink_cnt_k%0d", k), readdata, 32'(3 - (k % 4)));
            check($sformatf("blink_out_k%0d", k), out_port, 32'hCF ^ 32'((k / 4) % 2));
            if (k == 5) begin
                address = 3'd3; writedata = 32'h1; write_n = 1'b0;
            end
            @(posedge clk);
            #1;
            chipselect = 1'b0; write_n = 1'b1;
        end
        bus_write(3'd3, 32'h0);
        check("stop_out", out_port, 32'hCF);
        rd_check("stop_cnt", 3'd7, 32'h0);

        // One-shot: MASK=3, PERIOD=3, CONTROL=RUN|ONESHOT|IRQ_EN.
        bus_write(3'd0, 32'h0);
        bus_write(3'd1, 32'h3);
        bus_write(3'd2, 32'd3);
        bus_write(3'd3, 32'h7);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("os_out_k%0d", k), out_port, (k >= 3 && k < 6) ? 32'h3 : 32'h0);
            check($sformatf("os_irq_k%0d", k), {31'd0, irq}, (k >= 6) ? 32'h1 : 32'h0);
            step(1);
        end
        rd_check("os_ctrl", 3'd3, 32'h6);
        rd_check("os_status", 3'd4, 32'h2);
        step(1);
        bus_write(3'd4, 32'h2);
        check("w1c_irq", {31'd0, irq}, 32'h0);
        rd_check("w1c_status", 3'd4, 32'h0);
        step(1);

        // W1C landing on the same edge that sets DONE.
        bus_write(3'd3, 32'h7);
        step(5);
        bus_write(3'd4, 32'h2);
        check("race_irq", {31'd0, irq}, 32'h1);
        rd_check("race_status", 3'd4, 32'h2);
        step(1);
        bus_write(3'd4, 32'h2);
        check("race_clr_irq", {31'd0, irq}, 32'h0);

        // PERIOD change while running, then PERIOD=0 freeze, then stop.
        bus_write(3'd0, 32'h10);
        bus_write(3'd1, 32'h1);
        bus_write(3'd2, 32'd8);
        bus_write(3'd3, 32'h1);
        rd_check("per_status_run", 3'd4, 32'h1);
        bus_write(3'd2, 32'd2);
        for (int k = 1; k < 12; k++) begin
            check($sformatf("per_out_k%0d", k), out_port,
                  32'h10 ^ ((k >= 8 && k < 10) ? 32'h1 : 32'h0));
            step(1);
        end
        check("per_out_k12", out_port, 32'h11);
        bus_write(3'd2, 32'd0);
        step(5);
        check("freeze_out", out_port, 32'h11);
        rd_check("freeze_status", 3'd4, 32'h0);
        rd_check("freeze_cnt", 3'd7, 32'h0);
        step(1);
        bus_write(3'd3, 32'h0);
        check("per_stop_out", out_port, 32'h10);

        // Asynchronous reset during a one-shot pulse.
        bus_write(3'd0, 32'h0);
        bus_write(3'd1, 32'h3);
        bus_write(3'd2, 32'd3);
        bus_write(3'd3, 32'h7);
        step(3);
        check("ar_pulse_out", out_port, 32'h3);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_out", out_port, 32'h5);
        check("ar_irq", {31'd0, irq}, 32'h0);
        rd_check("ar_ctrl", 3'd3, 32'h0);
        rd_check("ar_status", 3'd4, 32'h0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        step(2);
        check("ar_after_out", out_port, 32'h5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
